// File: rtl/rv32_mc_controller.sv
// Multicycle RV32I(+M) control FSM: sequences fetch/decode/exec/mem/muldiv/wb over a shared datapath.
// Latency: one state per cycle; FETCH and MEM stall until i_mem_ready, MULDIV until i_muldiv_done.
// Backpressure: memory wait-states hold the state; an optional bus timeout forces a sticky TRAP.
module rv32_mc_controller #(
    parameter bit          ENABLE_M    = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter bit          RESET_GO    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_go,
    input  logic [31:0] i_instr,
    input  logic        i_mem_ready,
    input  logic        i_branch_taken,
    input  logic        i_muldiv_done,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_alu_op,
    output logic [1:0]  o_pc_source,
    output logic [1:0]  o_wb_sel,
    output logic        o_mem_addr_sel,
    output logic        o_mem_req,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_pc_write,
    output logic        o_reg_a_write,
    output logic        o_reg_b_write,
    output logic        o_alu_result_reg_write,
    output logic        o_regfile_write,
    output logic        o_muldiv_start,
    output logic        o_halted,
    output logic [1:0]  o_trap_cause,
    output logic [3:0]  o_state_vec
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_MULDIV = 4'd5,
        S_WB     = 4'd6,
        S_TRAP   = 4'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [15:0] TMO_LIMIT = 16'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_trap_cause;
    logic [1:0]  w_cause_nxt;
    logic [15:0] r_tmo_cnt;
    logic [6:0]  w_opcode;
    logic        w_mext;
    logic        w_ecall;
    logic        w_known;
    logic        w_illegal;
    logic        w_mem_wait;
    logic        w_timeout;
    logic        w_enter_mem;

    assign w_opcode   = i_instr[6:0];
    assign w_mext     = (w_opcode == OPC_OP) && (i_instr[31:25] == 7'b0000001);
    assign w_ecall    = (i_instr == 32'h0000_0073) || (i_instr == 32'h0010_0073);
    // CSR and other SYSTEM encodings are deliberately absent so they fall into illegal.
    assign w_known    = (w_opcode == OPC_LUI)   || (w_opcode == OPC_AUIPC)  ||
                        (w_opcode == OPC_JAL)   || (w_opcode == OPC_JALR)   ||
                        (w_opcode == OPC_BRANCH)|| (w_opcode == OPC_LOAD)   ||
                        (w_opcode == OPC_STORE) || (w_opcode == OPC_OPIMM)  ||
                        (w_opcode == OPC_OP)    || (w_opcode == OPC_FENCE);
    assign w_illegal  = !(w_known || w_ecall) || (w_mext && !ENABLE_M);
    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
    // Limit hits on the wait cycle that would bring the count to MEM_TIMEOUT; a ready in that cycle wins.
    assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait && ((r_tmo_cnt + 16'd1) == TMO_LIMIT);
    assign w_enter_mem = (w_state_nxt != r_state) &&
                         ((w_state_nxt == S_FETCH) || (w_state_nxt == S_MEM));

    // Next-state and trap-cause selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_trap_cause;
        case (r_state)
            S_IDLE:   if (i_go || RESET_GO) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (i_mem_ready) begin
                    w_state_nxt = S_DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'b11;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'b10;
                end else if (w_ecall) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'b01;
                end else if (w_opcode == OPC_AUIPC) begin
                    w_state_nxt = S_WB;
                end else if (w_opcode == OPC_FENCE) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_opcode)
                    OPC_OP:                w_state_nxt = w_mext ? S_MULDIV : S_WB;
                    OPC_OPIMM, OPC_LUI:    w_state_nxt = S_WB;
                    OPC_LOAD, OPC_STORE:   w_state_nxt = S_MEM;
                    default:               w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (i_mem_ready) begin
                    w_state_nxt = (w_opcode == OPC_LOAD) ? S_WB : S_FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'b11;
                end
            end
            S_MULDIV: if (i_muldiv_done) w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_TRAP:   w_state_nxt = S_TRAP;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // State, sticky trap cause and memory-wait counter; reset drops everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_trap_cause <= 2'b00;
            r_tmo_cnt    <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_cause <= w_cause_nxt;
            if (w_enter_mem) begin
                r_tmo_cnt <= 16'd0;
            end else if (w_mem_wait) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    // Control strobes: decoded from state and IR; only ready-gated strobes and branch pc_write are Mealy.
    always_comb begin
        o_alu_src_a            = 2'b00;
        o_alu_src_b            = 2'b00;
        o_alu_op               = 2'b00;
        o_pc_source            = 2'b00;
        o_wb_sel               = 2'b00;
        o_mem_addr_sel         = 1'b0;
        o_mem_req              = 1'b0;
        o_mem_write            = 1'b0;
        o_ir_write             = 1'b0;
        o_pc_write             = 1'b0;
        o_reg_a_write          = 1'b0;
        o_reg_b_write          = 1'b0;
        o_alu_result_reg_write = 1'b0;
        o_regfile_write        = 1'b0;
        o_muldiv_start         = 1'b0;
        o_halted               = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req   = 1'b1;
                o_alu_src_b = 2'b10;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_reg_a_write          = 1'b1;
                o_reg_b_write          = 1'b1;
                o_alu_src_a            = 2'b11;
                o_alu_src_b            = 2'b01;
                o_alu_result_reg_write = 1'b1;
            end
            S_EXEC: begin
                case (w_opcode)
                    OPC_OP, OPC_OPIMM: begin
                        if (w_mext) begin
                            o_muldiv_start = 1'b1;
                        end else begin
                            o_alu_src_a            = 2'b01;
                            o_alu_src_b            = (w_opcode == OPC_OP) ? 2'b00 : 2'b01;
                            o_alu_op               = 2'b01;
                            o_alu_result_reg_write = 1'b1;
                        end
                    end
                    OPC_LUI: begin
                        o_alu_src_a            = 2'b10;
                        o_alu_src_b            = 2'b01;
                        o_alu_result_reg_write = 1'b1;
                    end
                    OPC_BRANCH: begin
                        o_alu_src_a = 2'b01;
                        o_alu_op    = 2'b10;
                        o_pc_source = 2'b01;
                        o_pc_write  = i_branch_taken;
                    end
                    OPC_JAL: begin
                        o_pc_source     = 2'b01;
                        o_pc_write      = 1'b1;
                        o_regfile_write = 1'b1;
                        o_wb_sel        = 2'b10;
                    end
                    OPC_JALR: begin
                        o_alu_src_a     = 2'b01;
                        o_alu_src_b     = 2'b01;
                        o_pc_write      = 1'b1;
                        o_regfile_write = 1'b1;
                        o_wb_sel        = 2'b10;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        o_alu_src_a            = 2'b01;
                        o_alu_src_b            = 2'b01;
                        o_alu_result_reg_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_mem_write    = (w_opcode == OPC_STORE);
            end
            S_WB: begin
                o_regfile_write = 1'b1;
                if (w_opcode == OPC_LOAD)  o_wb_sel = 2'b01;
                else if (w_mext)           o_wb_sel = 2'b11;
            end
            S_TRAP:  o_halted = 1'b1;
            default: ;
        endcase
    end

    assign o_trap_cause = r_trap_cause;
    assign o_state_vec  = r_state;

endmodule

// File: tb/tb_rv32_mc_controller.sv
// Bench for rv32_mc_controller: per-instruction expected cycle traces built from the instruction
// class, compared against the DUT every cycle, plus literal pins on state order and strobe counts.
module tb_rv32_mc_controller;

    localparam int T = 4;  // timeout limit of the main instance

    typedef struct packed {
        logic [1:0] src_a, src_b, alu_op, pc_source, wb_sel;
        logic addr_sel, mem_req, mem_write, ir_write, pc_write, reg_a_write, reg_b_write;
        logic res_write, rf_write, md_start, halted;
        logic [1:0] cause;
        logic [3:0] state;
    } out_t;

    typedef struct packed {
        logic go;
        logic [31:0] instr;
        logic ready, taken, done;
        out_t exp;
    } cyc_t;

    localparam int C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BR = 4, C_LD = 5, C_ST = 6;
    localparam int C_OPI = 7, C_OP = 8, C_MUL = 9, C_FENCE = 10, C_ECALL = 11, C_ILL = 12;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_BEQ   = 32'h0000_0463;
    localparam logic [31:0] I_MUL   = 32'h0220_81B3;
    localparam logic [31:0] I_SW    = 32'h0020_A223;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;
    localparam logic [31:0] I_LUI   = 32'h1234_52B7;
    localparam logic [31:0] I_AUIPC = 32'h0000_1317;
    localparam logic [31:0] I_JAL   = 32'h0100_00EF;
    localparam logic [31:0] I_JALR  = 32'h0000_8067;
    localparam logic [31:0] I_FENCE = 32'h0FF0_000F;
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0, ready = 1'b0, taken = 1'b0, done = 1'b0;
    logic [31:0] instr = 32'h0;
    out_t        m_out, n_out;

    cyc_t  q[$];
    out_t  tr[$];
    int    checks = 0;
    int    failures = 0;
    string scn = "";
    logic [31:0] cur_instr = 32'h0;

    always #5 clk = ~clk;

    rv32_mc_controller #(.ENABLE_M(1'b1), .MEM_TIMEOUT(T), .RESET_GO(1'b0)) dut_m (
        .clk(clk), .rst(rst), .i_go(go), .i_instr(instr), .i_mem_ready(ready),
        .i_branch_taken(taken), .i_muldiv_done(done),
        .o_alu_src_a(m_out.src_a), .o_alu_src_b(m_out.src_b), .o_alu_op(m_out.alu_op),
        .o_pc_source(m_out.pc_source), .o_wb_sel(m_out.wb_sel), .o_mem_addr_sel(m_out.addr_sel),
        .o_mem_req(m_out.mem_req), .o_mem_write(m_out.mem_write), .o_ir_write(m_out.ir_write),
        .o_pc_write(m_out.pc_write), .o_reg_a_write(m_out.reg_a_write),
        .o_reg_b_write(m_out.reg_b_write), .o_alu_result_reg_write(m_out.res_write),
        .o_regfile_write(m_out.rf_write), .o_muldiv_start(m_out.md_start),
        .o_halted(m_out.halted), .o_trap_cause(m_out.cause), .o_state_vec(m_out.state)
    );

    rv32_mc_controller #(.ENABLE_M(1'b0), .MEM_TIMEOUT(0), .RESET_GO(1'b0)) dut_n (
        .clk(clk), .rst(rst), .i_go(go), .i_instr(instr), .i_mem_ready(ready),
        .i_branch_taken(taken), .i_muldiv_done(done),
        .o_alu_src_a(n_out.src_a), .o_alu_src_b(n_out.src_b), .o_alu_op(n_out.alu_op),
        .o_pc_source(n_out.pc_source), .o_wb_sel(n_out.wb_sel), .o_mem_addr_sel(n_out.addr_sel),
        .o_mem_req(n_out.mem_req), .o_mem_write(n_out.mem_write), .o_ir_write(n_out.ir_write),
        .o_pc_write(n_out.pc_write), .o_reg_a_write(n_out.reg_a_write),
        .o_reg_b_write(n_out.reg_b_write), .o_alu_result_reg_write(n_out.res_write),
        .o_regfile_write(n_out.rf_write), .o_muldiv_start(n_out.md_start),
        .o_halted(n_out.halted), .o_trap_cause(n_out.cause), .o_state_vec(n_out.state)
    );

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model: instruction class -> expected cycle trace ----------------
    function automatic int cls(logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (ins == 32'h0000_0073 || ins == 32'h0010_0073) return C_ECALL;
        case (op)
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b1100011: return C_BR;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b0010011: return C_OPI;
            7'b0110011: return (ins[31:25] == 7'b0000001) ? C_MUL : C_OP;
            7'b0001111: return C_FENCE;
            default:    return C_ILL;
        endcase
    endfunction

    function automatic out_t o(int st);
        out_t e;
        e = '0;
        e.state = 4'(st);
        return e;
    endfunction

    function automatic out_t f_wait();
        out_t e;
        e = o(1);
        e.mem_req = 1'b1;
        e.src_b = 2'b10;
        return e;
    endfunction

    task automatic push(out_t e, logic rd, logic tk, logic dn, logic g);
        cyc_t c;
        c.go = g; c.instr = cur_instr; c.ready = rd; c.taken = tk; c.done = dn; c.exp = e;
        q.push_back(c);
    endtask

    // st=1 instruction fetch, st=4 data access; stops after T unanswered cycles
    task automatic m_wait(int st, int waits, logic store, output bit trapped);
        out_t e;
        trapped = 1'b0;
        if (st == 1) e = f_wait();
        else begin
            e = o(4); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_write = store;
        end
        for (int i = 0; i < waits; i++) begin
            push(e, 1'b0, 1'b0, 1'b0, 1'b0);
            if (T > 0 && i + 1 == T) begin
                trapped = 1'b1;
                return;
            end
        end
        if (st == 1) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
        push(e, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic m_trap(int cause, int n);
        out_t e;
        e = o(7); e.halted = 1'b1; e.cause = 2'(cause);
        for (int i = 0; i < n; i++) push(e, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic m_wb(int sel);
        out_t e;
        e = o(6); e.rf_write = 1'b1; e.wb_sel = 2'(sel);
        push(e, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic m_idle();
        push(o(0), 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic m_instr(logic [31:0] ins, int fw, int mw, logic tk, int mdl);
        out_t e;
        bit   trp;
        int   k;
        cur_instr = ins;
        k = cls(ins);
        m_wait(1, fw, 1'b0, trp);
        if (trp) begin m_trap(3, 2); return; end
        e = o(2); e.reg_a_write = 1'b1; e.reg_b_write = 1'b1;
        e.src_a = 2'b11; e.src_b = 2'b01; e.res_write = 1'b1;
        push(e, 1'b0, 1'b0, 1'b0, 1'b0);
        e = o(3);
        case (k)
            C_FENCE: ;
            C_ECALL: m_trap(1, 2);
            C_ILL:   m_trap(2, 2);
            C_AUIPC: m_wb(0);
            C_OP, C_OPI: begin
                e.src_a = 2'b01; e.src_b = (k == C_OP) ? 2'b00 : 2'b01;
                e.alu_op = 2'b01; e.res_write = 1'b1;
                push(e, 1'b0, 1'b0, 1'b0, 1'b0);
                m_wb(0);
            end
            C_LUI: begin
                e.src_a = 2'b10; e.src_b = 2'b01; e.res_write = 1'b1;
                push(e, 1'b0, 1'b0, 1'b0, 1'b0);
                m_wb(0);
            end
            C_BR: begin
                e.src_a = 2'b01; e.alu_op = 2'b10; e.pc_source = 2'b01; e.pc_write = tk;
                push(e, 1'b0, tk, 1'b0, 1'b0);
            end
            C_JAL: begin
                e.pc_source = 2'b01; e.pc_write = 1'b1; e.rf_write = 1'b1; e.wb_sel = 2'b10;
                push(e, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            C_JALR: begin
                e.src_a = 2'b01; e.src_b = 2'b01; e.pc_write = 1'b1;
                e.rf_write = 1'b1; e.wb_sel = 2'b10;
                push(e, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            C_LD, C_ST: begin
                e.src_a = 2'b01; e.src_b = 2'b01; e.res_write = 1'b1;
                push(e, 1'b0, 1'b0, 1'b0, 1'b0);
                m_wait(4, mw, (k == C_ST), trp);
                if (trp) m_trap(3, 2);
                else if (k == C_LD) m_wb(1);
            end
            C_MUL: begin
                // done raised alongside start must not count
                e.md_start = 1'b1;
                push(e, 1'b0, 1'b0, 1'b1, 1'b0);
                e = o(5);
                for (int i = 0; i < mdl - 1; i++) push(e, 1'b0, 1'b0, 1'b0, 1'b0);
                push(e, 1'b0, 1'b0, 1'b1, 1'b0);
                m_wb(3);
            end
            default: ;
        endcase
    endtask

    // ---------------- driver + per-cycle compare ----------------
    task automatic run_q();
        cyc_t c;
        int   n;
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            go = c.go; instr = c.instr; ready = c.ready; taken = c.taken; done = c.done;
            @(negedge clk);
            chk($sformatf("%s cyc%0d", scn, n), 64'(m_out), 64'(c.exp));
            tr.push_back(m_out);
            n++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; go = 1'b0; ready = 1'b0; taken = 1'b0; done = 1'b0;
        @(negedge clk);
        chk({scn, " reset outputs"}, 64'(m_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tr.delete();
        q.delete();
    endtask

    function automatic int count(int st, int field);
        int n;
        n = 0;
        foreach (tr[i]) begin
            if (st < 0 || tr[i].state == 4'(st)) begin
                case (field)
                    0: n += int'(tr[i].mem_req);
                    1: n += int'(tr[i].md_start);
                    2: n += int'(tr[i].rf_write);
                    default: n += 1;
                endcase
            end
        end
        return n;
    endfunction

    initial begin
        logic [23:0] states;
        logic [1:0]  pw;
        bit          dummy;

        // 1: addi, memory always ready
        scn = "addi";
        do_reset();
        m_idle();
        m_instr(I_ADDI, 0, 0, 1'b0, 0);
        push(f_wait(), 1'b0, 1'b0, 1'b0, 1'b0);
        run_q();
        states = '0;
        for (int i = 0; i < 6; i++) states = {states[19:0], tr[i].state};
        chk("addi state order", 64'(states), 64'h01_2361);
        chk("addi wb rf_write/wb_sel", 64'({tr[4].rf_write, tr[4].wb_sel}), 64'h4);

        // 2: lw with 3 data wait-states (reaches the timeout limit in the ready cycle)
        scn = "lw";
        do_reset();
        m_idle();
        m_instr(I_LW, 1, 3, 1'b0, 0);
        run_q();
        chk("lw mem_req cycles in MEM", 64'(count(4, 0)), 64'd4);
        chk("lw wb_sel", 64'(tr[tr.size()-1].wb_sel), 64'd1);

        // 3: beq taken then not taken
        scn = "beq";
        do_reset();
        m_idle();
        m_instr(I_BEQ, 0, 0, 1'b1, 0);
        m_instr(I_BEQ, 0, 0, 1'b0, 0);
        push(f_wait(), 1'b0, 1'b0, 1'b0, 1'b0);
        run_q();
        pw = '0;
        foreach (tr[i]) if (tr[i].state == 4'd3) pw = {pw[0], tr[i].pc_write};
        chk("beq exec pc_write seq", 64'(pw), 64'h2);
        chk("beq regfile_write count", 64'(count(-1, 2)), 64'd0);

        // 4: mul, done on the fifth MULDIV cycle; M-disabled instance traps illegal
        scn = "mul";
        do_reset();
        m_idle();
        m_instr(I_MUL, 0, 0, 1'b0, 5);
        push(f_wait(), 1'b0, 1'b0, 1'b0, 1'b0);
        run_q();
        chk("mul start pulses", 64'(count(-1, 1)), 64'd1);
        chk("mul MULDIV cycles", 64'(count(5, 3)), 64'd5);
        chk("mul wb_sel", 64'(tr[tr.size()-2].wb_sel), 64'd3);
        chk("noM halted/cause", 64'({n_out.halted, n_out.cause}), 64'h6);

        // 5: fetch never answered -> bus timeout after T waits, sticky
        scn = "tmo";
        do_reset();
        m_idle();
        m_instr(I_ADDI, 6, 0, 1'b0, 0);
        run_q();
        chk("noTMO still fetching", 64'({n_out.state, n_out.mem_req}), 64'h3);
        m_trap(3, 0);
        for (int i = 0; i < 2; i++) begin
            out_t e;
            e = o(7); e.halted = 1'b1; e.cause = 2'b11;
            push(e, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        run_q();
        chk("tmo fetch mem_req cycles", 64'(count(1, 0)), 64'd4);
        chk("tmo halted/cause", 64'({m_out.halted, m_out.cause}), 64'h7);

        // 6: async reset mid-MEM, then ecall
        scn = "rstmem";
        do_reset();
        m_idle();
        m_instr(I_SW, 0, 2, 1'b0, 0);
        dummy = 1'b0;
        void'(q.pop_back());
        run_q();
        chk("sw mem_write in MEM", 64'({tr[tr.size()-1].state, tr[tr.size()-1].mem_write}), 64'h9);
        #1 rst = 1'b1;
        #1 chk("async rst outputs", 64'(m_out), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        scn = "ecall";
        tr.delete();
        m_idle();
        m_instr(I_ECALL, 0, 0, 1'b0, 0);
        run_q();
        chk("ecall halted/cause", 64'({m_out.halted, m_out.cause}), 64'h5);

        // 7: remaining classes, one fetch wait each, ending on an illegal word
        scn = "mix";
        do_reset();
        m_idle();
        m_instr(I_LUI,   1, 0, 1'b0, 0);
        m_instr(I_AUIPC, 1, 0, 1'b0, 0);
        m_instr(I_JAL,   1, 0, 1'b0, 0);
        m_instr(I_JALR,  1, 0, 1'b0, 0);
        m_instr(I_FENCE, 1, 0, 1'b0, 0);
        m_instr(I_SW,    1, 1, 1'b0, 0);
        m_instr(I_BAD,   1, 0, 1'b0, 0);
        run_q();
        chk("mix regfile writes", 64'(count(-1, 2)), 64'd4);
        chk("mix illegal halted/cause", 64'({m_out.halted, m_out.cause}), 64'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
